// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared types and constants for the configuration loader
package config_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CFG_WORD_WIDTH = 32;
    localparam int MAX_TILES      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // A single tile still needs a one-bit index.
    function automatic int tile_idx_width(input int num_tiles);
        return (num_tiles > 1) ? $clog2(num_tiles) : 1;
    endfunction

endpackage

// File: rtl/config_word_buffer.sv
// rtl/config_word_buffer.sv - per-tile word store with byte-lane writes and word reads
module config_word_buffer
    import config_pkg::*;
#(
    parameter int NUM_TILES = 4,
    parameter int TW        = tile_idx_width(NUM_TILES)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [TW-1:0]             wr_tile,
    input  logic [1:0]                wr_lane,
    input  logic [7:0]                wr_data,
    input  logic [TW-1:0]             rd_tile,
    output logic [CFG_WORD_WIDTH-1:0] rd_data
);

    // Contents are only ever read after a full overwrite, so no reset is needed.
    logic [CFG_WORD_WIDTH-1:0] mem [NUM_TILES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_tile][{wr_lane, 3'b000} +: 8] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[rd_tile];
    end

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - byte-serial config stream loader with checksum-gated tile commit
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_TILES  = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] config_data,
    output logic [NUM_TILES-1:0]  config_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TOTAL = BYTES_PER_WORD * NUM_TILES;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = tile_idx_width(NUM_TILES);

    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
    localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

    state_t                    state;
    logic [CW-1:0]             byte_cnt;
    logic [7:0]                xor_acc;
    logic [7:0]                chk_byte;
    logic [TW-1:0]             idx;
    logic [TW-1:0]             next_idx;
    logic                      accept;
    logic                      wr_en;
    logic [TW-1:0]             wr_tile;
    logic [TW-1:0]             rd_tile;
    logic [CFG_WORD_WIDTH-1:0] rd_data;

    always_comb begin
        accept   = (state == ST_RECV) && in_valid && in_ready;
        wr_en    = accept && (byte_cnt != TOTAL_C);
        wr_tile  = TW'(byte_cnt >> 2);
        next_idx = (idx == LAST_TILE) ? '0 : idx + 1'b1;
        // The word presented next cycle: tile 0 out of CHECK, the following tile during COMMIT.
        rd_tile  = (state == ST_COMMIT) ? next_idx : '0;
    end

    config_word_buffer #(
        .NUM_TILES (NUM_TILES),
        .TW        (TW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_tile (wr_tile),
        .wr_lane (byte_cnt[1:0]),
        .wr_data (in_data),
        .rd_tile (rd_tile),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            xor_acc     <= '0;
            chk_byte    <= '0;
            idx         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            config_en   <= '0;
            config_data <= '0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            config_en   <= '0;
            config_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RECV;
                        byte_cnt <= '0;
                        xor_acc  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        if (byte_cnt == TOTAL_C) begin
                            chk_byte <= in_data;
                            in_ready <= 1'b0;
                            state    <= ST_CHECK;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            xor_acc  <= xor_acc ^ in_data;
                        end
                    end
                end
                ST_CHECK: begin
                    if (chk_byte == xor_acc) begin
                        state       <= ST_COMMIT;
                        idx         <= '0;
                        config_en   <= NUM_TILES'(1);
                        config_data <= WORD_WIDTH'(rd_data);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (idx == LAST_TILE) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx         <= next_idx;
                        config_en   <= NUM_TILES'(1) << next_idx;
                        config_data <= WORD_WIDTH'(rd_data);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed bench for config_loader with a transaction-level model
module tb_config_loader;

    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [31:0]   config_data;
    logic [NT-1:0] config_en;
    logic          busy;
    logic          done;
    logic          err;

    config_loader #(.NUM_TILES(NT), .WORD_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .config_data (config_data),
        .config_en   (config_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic          rdy;
        logic          done;
        logic          err;
        logic [NT-1:0] en;
        logic [31:0]   data;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 0;

    logic          m_busy = 0, m_rdy = 0, m_done = 0, m_err = 0;
    logic [NT-1:0] m_en   = '0;
    logic [31:0]   m_data = '0;
    logic [7:0]    rx[$];
    exp_t          plan[$];

    logic [31:0] tiles [NT];
    logic        tile_clr;

    int hs_cyc, done_cyc, first_en, en_cnt, err_seen;

    logic [7:0] s1 [9];
    logic [7:0] s2 [9];
    logic [7:0] s6 [9];
    logic [7:0] pinq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] fold_xor(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * NT; i++) x ^= q[i];
        return x;
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] q[$], input int k);
        return {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
    endfunction

    // Model: start accepted only while idle (busy low), bytes accepted on in_ready,
    // and once the checksum lands the remaining outputs follow a fixed schedule.
    initial begin
        logic pb, pr;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (tile_clr) begin
                for (int k = 0; k < NT; k++) tiles[k] = '0;
            end else begin
                for (int k = 0; k < NT; k++) if (config_en[k]) tiles[k] = config_data;
            end
            pb = m_busy;
            pr = m_rdy;
            if (rst) begin
                rx.delete();
                plan.delete();
                m_busy = 0; m_rdy = 0; m_done = 0; m_err = 0; m_en = '0; m_data = '0;
            end else begin
                m_en = '0; m_data = '0; m_done = 0; m_err = 0;
                if (!pb && start) begin
                    rx.delete();
                    m_busy = 1;
                    m_rdy  = 1;
                end else if (pr && in_valid) begin
                    rx.push_back(in_data);
                    if (rx.size() == 4 * NT + 1) begin
                        e.busy = 1; e.rdy = 0; e.done = 0; e.err = 0; e.en = '0; e.data = '0;
                        plan.push_back(e);
                        if (fold_xor(rx) == rx[4*NT]) begin
                            for (int k = 0; k < NT; k++) begin
                                e.en = NT'(1 << k);
                                e.data = word_of(rx, k);
                                plan.push_back(e);
                            end
                            e.busy = 0; e.done = 1; e.en = '0; e.data = '0;
                            plan.push_back(e);
                        end else begin
                            e.busy = 0; e.done = 1; e.err = 1;
                            plan.push_back(e);
                        end
                    end
                end
                if (plan.size() > 0 && !(!pb && start) && !(pr && in_valid && rx.size() < 4 * NT + 1)) begin
                    e = plan.pop_front();
                    m_busy = e.busy; m_rdy = e.rdy; m_done = e.done; m_err = e.err;
                    m_en = e.en; m_data = e.data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy",        32'(busy),      32'(m_busy));
            check("in_ready",    32'(in_ready),  32'(m_rdy));
            check("config_en",   32'(config_en), 32'(m_en));
            check("config_data", config_data,    m_data);
            check("done",        32'(done),      32'(m_done));
            check("err",         32'(err),       32'(m_err));
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1;
                hs_cyc = cyc;
            end
        end
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input logic [7:0] b [9], input int n, input bit gaps, input int start_idx);
        for (int i = 0; i < n; i++) begin
            start = (i == start_idx);
            send_byte(b[i]);
            start = 1'b0;
            if (gaps && i != n - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit commit_start, input bit chain);
        bit seen;
        seen = 0; first_en = -1; en_cnt = 0; err_seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = commit_start && (config_en == NT'(1));
            if (config_en != '0) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
            end
            if (err) err_seen = 1;
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                if (chain) start = 1'b1;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_tiles();
        tile_clr = 1'b1;
        @(posedge clk); #1;
        tile_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        s1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        s2 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
        s6 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        for (int i = 0; i < 9; i++) pinq.push_back(s1[i]);
        check("pin_xor_s1",   32'(fold_xor(pinq)), 32'h2A);
        check("pin_word0_s1", word_of(pinq, 0),    32'h12345678);
        check("pin_word1_s1", word_of(pinq, 1),    32'hDEADBEEF);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tile_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; tile_clr = 1'b0; armed = 1;
        @(negedge clk);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_en",       32'(config_en), 32'd0);
        check("rst_data",     config_data,    32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_err",      32'(err),       32'd0);
        @(posedge clk); #1;

        // 1: clean load
        do_start();
        send_stream(s1, 9, 0, -1);
        wait_done(0, 0);
        check("s1_tile0",    tiles[0],               32'h12345678);
        check("s1_tile1",    tiles[1],               32'hDEADBEEF);
        check("s1_done_lat", 32'(done_cyc - hs_cyc), 32'd3);
        check("s1_err",      32'(err_seen),          32'd0);
        check("s1_en_cnt",   32'(en_cnt),            32'd2);

        // 2: bad checksum leaves tiles untouched
        do_start();
        send_stream(s2, 9, 0, -1);
        wait_done(0, 0);
        check("s2_done_lat", 32'(done_cyc - hs_cyc), 32'd1);
        check("s2_err",      32'(err_seen),          32'd1);
        check("s2_en_cnt",   32'(en_cnt),            32'd0);
        check("s2_tile0",    tiles[0],               32'h12345678);
        check("s2_tile1",    tiles[1],               32'hDEADBEEF);

        // 3: in_valid gaps
        clear_tiles();
        do_start();
        send_stream(s1, 9, 1, -1);
        wait_done(0, 0);
        check("s3_tile0",      tiles[0],               32'h12345678);
        check("s3_tile1",      tiles[1],               32'hDEADBEEF);
        check("s3_commit_lat", 32'(first_en - hs_cyc), 32'd1);

        // 4: stray starts during RECV and COMMIT
        clear_tiles();
        do_start();
        send_stream(s1, 9, 0, 3);
        wait_done(1, 0);
        check("s4_tile0",    tiles[0],               32'h12345678);
        check("s4_tile1",    tiles[1],               32'hDEADBEEF);
        check("s4_en_cnt",   32'(en_cnt),            32'd2);
        check("s4_done_lat", 32'(done_cyc - hs_cyc), 32'd3);

        // 5: reset mid-load, then a full load
        clear_tiles();
        do_start();
        send_stream(s1, 5, 0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s5_busy",     32'(busy),      32'd0);
        check("s5_in_ready", 32'(in_ready),  32'd0);
        check("s5_en",       32'(config_en), 32'd0);
        check("s5_done",     32'(done),      32'd0);
        @(posedge clk); #1;
        do_start();
        send_stream(s1, 9, 0, -1);
        wait_done(0, 0);
        check("s5_tile0", tiles[0], 32'h12345678);
        check("s5_tile1", tiles[1], 32'hDEADBEEF);

        // 6: second start in the done cycle
        clear_tiles();
        do_start();
        send_stream(s1, 9, 0, -1);
        wait_done(0, 1);
        send_stream(s6, 9, 0, -1);
        wait_done(0, 0);
        check("s6_tile0",  tiles[0],    32'h00000000);
        check("s6_tile1",  tiles[1],    32'hFFFFFFFF);
        check("s6_en_cnt", 32'(en_cnt), 32'd2);
        check("s6_err",    32'(err_seen), 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
